exec_step_ctrl: RTL and testbench

- Run/step controller between the board clock domain and the ARM core. Generates the core's per-cycle clock enable.
- Operating modes: free-run, single-step from a push button, run-N-cycles burst, halt.
- Stops the core before executing an instruction whose PC matches any enabled hardware breakpoint.
- Counts executed cycles. Replaces the fixed clk/clk_step/clk_select scheme with a parametrised, debuggable controller.

---
 rtl/exec_step_pkg.sv | 30 +++
 rtl/step_sync_edge.sv | 45 ++++
 rtl/exec_step_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_exec_step_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_step_pkg.sv
// Shared types and constants for the run/step execution controller.
//   state_t : FSM state encoding (3-bit, codes visible on the state port)
//   mode_t  : operating-mode encoding of the 2-bit mode input
//   idx_width(): width of a slot index for n comparators (minimum 1)
package exec_step_pkg;

  localparam logic [2:0] STATE_IDLE  = 3'd0;
  localparam logic [2:0] STATE_RUN   = 3'd1;
  localparam logic [2:0] STATE_BURST = 3'd2;
  localparam logic [2:0] STATE_BREAK = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = STATE_IDLE,
    ST_RUN   = STATE_RUN,
    ST_BURST = STATE_BURST,
    ST_BREAK = STATE_BREAK
  } state_t;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'b00,
    MODE_STEP  = 2'b01,
    MODE_RUN_N = 2'b10,
    MODE_HALT  = 2'b11
  } mode_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/step_sync_edge.sv
// Step push-button conditioning: 2-flop synchronizer followed by a
// rising-edge detector. Produces a registered single-cycle fire pulse
// three clk edges after the button rises.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset
//   btn_i   : raw push button, asynchronous to clk
//   fire_o  : one-cycle pulse per press
module step_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic fire_o
);

  logic       s1_q, s2_q;
  logic       prev_q;
  logic [1:0] vld_q;
  logic       fire_q;

  // vld_q tracks how far real button samples have propagated into the
  // synchronizer. Until s2_q holds a genuine sample, prev_q stays at its
  // reset value of 1, so a button held through reset never looks like a
  // fresh rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b1;
      vld_q  <= 2'b00;
      fire_q <= 1'b0;
    end else begin
      s1_q   <= btn_i;
      s2_q   <= s1_q;
      vld_q  <= {vld_q[0], 1'b1};
      if (vld_q[1]) begin
        prev_q <= s2_q;
      end
      fire_q <= vld_q[1] & s2_q & ~prev_q;
    end
  end

  assign fire_o = fire_q;

endmodule

// File: rtl/exec_step_ctrl.sv
// Run/step controller producing the ARM core's per-cycle clock enable.
// Modes: free-run, single-step from push button, run-N burst, halt.
// Hardware breakpoints stop the core before the matching instruction.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   mode      : 00 RUN, 01 STEP, 10 RUN_N, 11 HALT
//   step_btn  : raw step button (asynchronous)
//   start     : pulse starting a RUN_N burst of run_n cycles
//   resume    : pulse leaving BREAK
//   pc        : PC of the instruction executed when cpu_en=1
//   bp_addr   : NUM_BP packed breakpoint addresses
//   bp_en     : per-slot breakpoint enable
//   cpu_en    : combinational core clock enable
//   state     : FSM state code
//   cycle_cnt : saturating count of enabled cycles
//   bp_hit    : one-cycle pulse in the first BREAK cycle
//   bp_idx    : lowest matching slot of the last hit
//   done      : one-cycle pulse when a burst completes
module exec_step_ctrl
  import exec_step_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int PC_W   = 32,
  parameter int NUM_BP = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [1:0]                       mode,
  input  logic                             step_btn,
  input  logic                             start,
  input  logic [CNT_W-1:0]                 run_n,
  input  logic                             resume,
  input  logic [PC_W-1:0]                  pc,
  input  logic [NUM_BP*PC_W-1:0]           bp_addr,
  input  logic [NUM_BP-1:0]                bp_en,
  output logic                             cpu_en,
  output logic [2:0]                       state,
  output logic [CNT_W-1:0]                 cycle_cnt,
  output logic                             bp_hit,
  output logic [idx_width(NUM_BP)-1:0]     bp_idx,
  output logic                             done
);

  localparam int IDX_W = idx_width(NUM_BP);

  mode_t            mode_w;
  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             skip_q, skip_d;
  logic             bp_hit_q, bp_hit_d;
  logic [IDX_W-1:0] bp_idx_q, bp_idx_d;
  logic             done_q, done_d;

  logic              step_fire;
  logic [NUM_BP-1:0] slot_match;
  logic              bp_match;
  logic [IDX_W-1:0]  match_idx;
  logic              run_like;

  assign mode_w = mode_t'(mode);

  step_sync_edge u_step (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (step_btn),
    .fire_o (step_fire)
  );

  for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp
    assign slot_match[gi] = bp_en[gi] && (pc == bp_addr[gi*PC_W +: PC_W]);
  end

  // skip masks the breakpoint for the single enabled cycle after resume,
  // letting the core execute the instruction it stopped in front of.
  assign bp_match = (|slot_match) && !skip_q;

  // Scan downward so the lowest matching slot wins.
  always_comb begin
    match_idx = '0;
    for (int k = NUM_BP - 1; k >= 0; k--) begin
      if (slot_match[k]) match_idx = IDX_W'(k);
    end
  end

  assign run_like = (state_q == ST_RUN) || (state_q == ST_BURST);
  assign cpu_en   = (mode_w != MODE_HALT) && (step_fire || (run_like && !bp_match));

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    remaining_d = remaining_q;
    skip_d      = skip_q && !cpu_en;
    bp_hit_d    = 1'b0;
    bp_idx_d    = bp_idx_q;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (mode_w == MODE_RUN) begin
          state_d = ST_RUN;
        end else if (mode_w == MODE_RUN_N && start) begin
          if (run_n != '0) begin
            state_d     = ST_BURST;
            remaining_d = run_n;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (mode_w != MODE_RUN) begin
          state_d = ST_IDLE;
        end else if (bp_match) begin
          state_d  = ST_BREAK;
          ret_d    = ST_RUN;
          bp_hit_d = 1'b1;
          bp_idx_d = match_idx;
        end
      end
      ST_BURST: begin
        if (mode_w != MODE_RUN_N) begin
          state_d = ST_IDLE;
        end else if (bp_match) begin
          state_d  = ST_BREAK;
          ret_d    = ST_BURST;
          bp_hit_d = 1'b1;
          bp_idx_d = match_idx;
        end else if (cpu_en) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        // HALT takes priority over a simultaneous resume.
        if (mode_w == MODE_HALT) begin
          state_d = ST_IDLE;
        end else if (resume) begin
          state_d = ret_q;
          skip_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pending skip must not leak into a later run or step from IDLE.
    if (state_d == ST_IDLE) skip_d = 1'b0;
  end

  assign cycle_cnt_d = (cpu_en && (cycle_cnt_q != '1)) ? cycle_cnt_q + CNT_W'(1) : cycle_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ret_q       <= ST_RUN;
      remaining_q <= '0;
      cycle_cnt_q <= '0;
      skip_q      <= 1'b0;
      bp_hit_q    <= 1'b0;
      bp_idx_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      remaining_q <= remaining_d;
      cycle_cnt_q <= cycle_cnt_d;
      skip_q      <= skip_d;
      bp_hit_q    <= bp_hit_d;
      bp_idx_q    <= bp_idx_d;
      done_q      <= done_d;
    end
  end

  assign state     = state_q;
  assign cycle_cnt = cycle_cnt_q;
  assign bp_hit    = bp_hit_q;
  assign bp_idx    = bp_idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_exec_step_ctrl.sv
// Directed bench for exec_step_ctrl: free-run, bursts, breakpoints,
// step button latency and reset behaviour, HALT/resume priority.
module tb_exec_step_ctrl;

  localparam int CNT_W  = 32;
  localparam int PC_W   = 32;
  localparam int NUM_BP = 2;

  localparam logic [1:0] M_RUN   = 2'b00;
  localparam logic [1:0] M_STEP  = 2'b01;
  localparam logic [1:0] M_RUN_N = 2'b10;
  localparam logic [1:0] M_HALT  = 2'b11;

  logic                   clk;
  logic                   rst;
  logic [1:0]             mode;
  logic                   step_btn;
  logic                   start;
  logic [CNT_W-1:0]       run_n;
  logic                   resume;
  logic [PC_W-1:0]        pc;
  logic [NUM_BP*PC_W-1:0] bp_addr;
  logic [NUM_BP-1:0]      bp_en;
  logic                   cpu_en;
  logic [2:0]             state;
  logic [CNT_W-1:0]       cycle_cnt;
  logic                   bp_hit;
  logic [0:0]             bp_idx;
  logic                   done;

  int checks = 0;
  int errors = 0;
  int n;
  int exp_cnt;

  exec_step_ctrl #(.CNT_W(CNT_W), .PC_W(PC_W), .NUM_BP(NUM_BP)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .step_btn  (step_btn),
    .start     (start),
    .run_n     (run_n),
    .resume    (resume),
    .pc        (pc),
    .bp_addr   (bp_addr),
    .bp_en     (bp_en),
    .cpu_en    (cpu_en),
    .state     (state),
    .cycle_cnt (cycle_cnt),
    .bp_hit    (bp_hit),
    .bp_idx    (bp_idx),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("chk  %s got=%0h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; mode = M_RUN; step_btn = 1'b0; start = 1'b0; run_n = '0;
    resume = 1'b0; pc = '0; bp_addr = '0; bp_en = '0;
    cyc(); cyc();
    check_eq("rst_state", state, 0);
    check_eq("rst_cnt", cycle_cnt, 0);
    check_eq("rst_bp_hit", bp_hit, 0);
    check_eq("rst_bp_idx", bp_idx, 0);
    check_eq("rst_done", done, 0);

    // 1: free run, 100 enabled cycles
    rst = 1'b0;
    #1 check_eq("t1_idle_en", cpu_en, 0);
    cyc();
    check_eq("t1_state_run", state, 1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (cpu_en) n++;
      cyc();
    end
    exp_cnt = 100;
    check_eq("t1_en_cycles", n, 100);
    check_eq("t1_cnt", cycle_cnt, exp_cnt);
    mode = M_HALT;
    #1 check_eq("t1_halt_en", cpu_en, 0);
    cyc();
    check_eq("t1_halt_idle", state, 0);

    // 2: burst of 5 (a start inside the burst is ignored), then run_n=0
    mode = M_RUN_N; run_n = 5; start = 1'b1;
    #1 check_eq("t2_start_en", cpu_en, 0);
    cyc();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin start = 1'b1; run_n = 99; end
      #1;
      if (cpu_en && state == 3'd2) n++;
      cyc();
      start = 1'b0;
    end
    exp_cnt += 5;
    check_eq("t2_en_cycles", n, 5);
    check_eq("t2_done", done, 1);
    check_eq("t2_state", state, 0);
    check_eq("t2_cnt", cycle_cnt, exp_cnt);
    #1 check_eq("t2_after_en", cpu_en, 0);
    cyc();
    check_eq("t2_done_clr", done, 0);
    run_n = 0; start = 1'b1;
    #1 check_eq("t2z_en", cpu_en, 0);
    cyc();
    start = 1'b0;
    check_eq("t2z_done", done, 1);
    check_eq("t2z_state", state, 0);
    check_eq("t2z_cnt", cycle_cnt, exp_cnt);
    cyc();
    check_eq("t2z_done_clr", done, 0);

    // 3: breakpoint in RUN, resume past it, then slot 1 hit
    bp_addr = {32'h0000_0100, 32'h0000_0040}; bp_en = 2'b01;
    pc = 32'h38; mode = M_RUN;
    cyc();
    check_eq("t3_en_38", cpu_en, 1);
    cyc();
    pc = 32'h3C;
    #1 check_eq("t3_en_3c", cpu_en, 1);
    cyc();
    pc = 32'h40;
    #1 check_eq("t3_en_40", cpu_en, 0);
    check_eq("t3_state_pre", state, 1);
    cyc();
    check_eq("t3_state_brk", state, 3);
    check_eq("t3_bp_hit", bp_hit, 1);
    check_eq("t3_bp_idx", bp_idx, 0);
    check_eq("t3_brk_en", cpu_en, 0);
    cyc();
    check_eq("t3_bp_hit_clr", bp_hit, 0);
    check_eq("t3_brk_hold", state, 3);
    resume = 1'b1;
    #1 check_eq("t3_resume_en", cpu_en, 0);
    cyc();
    resume = 1'b0;
    #1 check_eq("t3_state_back", state, 1);
    check_eq("t3_skip_en", cpu_en, 1);
    cyc();
    pc = 32'h44;
    #1 check_eq("t3_en_44", cpu_en, 1);
    cyc();
    exp_cnt += 4;
    check_eq("t3_cnt", cycle_cnt, exp_cnt);
    bp_addr = {32'h0000_0050, 32'h0000_0040}; bp_en = 2'b11; pc = 32'h50;
    #1 check_eq("t3_en_50", cpu_en, 0);
    cyc();
    check_eq("t3_slot1_state", state, 3);
    check_eq("t3_slot1_idx", bp_idx, 1);
    check_eq("t3_slot1_hit", bp_hit, 1);
    mode = M_HALT; bp_en = 2'b00;
    cyc();
    check_eq("t3_halt_idle", state, 0);

    // 4: step button, one pulse three edges after the rise
    mode = M_STEP;
    cyc(); cyc();
    step_btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      check_eq($sformatf("t4_step_c%0d", i), cpu_en, (i == 3) ? 1 : 0);
    end
    step_btn = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (cpu_en) n++;
    end
    exp_cnt += 1;
    check_eq("t4_release_en", n, 0);
    check_eq("t4_cnt", cycle_cnt, exp_cnt);
    check_eq("t4_state", state, 0);

    // 4b: button held through reset never fires
    step_btn = 1'b1; rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (cpu_en) n++;
      cyc();
    end
    exp_cnt = 0;
    check_eq("t4b_held_en", n, 0);
    check_eq("t4b_cnt", cycle_cnt, exp_cnt);
    step_btn = 1'b0;
    cyc(); cyc(); cyc();

    // 5: burst of 8 with breakpoint after 3 enables
    mode = M_RUN_N; run_n = 8; bp_addr = {32'h0, 32'h0000_0200}; bp_en = 2'b01;
    pc = 32'h0; start = 1'b1;
    cyc();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h100 + 32'(4 * i);
      #1;
      if (cpu_en) n++;
      cyc();
    end
    check_eq("t5_pre_en", n, 3);
    pc = 32'h200;
    #1 check_eq("t5_bp_en", cpu_en, 0);
    cyc();
    check_eq("t5_state_brk", state, 3);
    check_eq("t5_bp_hit", bp_hit, 1);
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    check_eq("t5_state_back", state, 2);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      pc = 32'h200 + 32'(4 * i);
      #1;
      if (cpu_en) n++;
      cyc();
    end
    exp_cnt += 8;
    check_eq("t5_post_en", n, 5);
    check_eq("t5_done", done, 1);
    check_eq("t5_state_idle", state, 0);
    check_eq("t5_cnt", cycle_cnt, exp_cnt);

    // 5b: HALT mid-burst aborts without done
    bp_en = 2'b00; run_n = 8; start = 1'b1;
    cyc();
    start = 1'b0;
    #1 check_eq("t5b_en0", cpu_en, 1);
    cyc();
    check_eq("t5b_en1", cpu_en, 1);
    cyc();
    mode = M_HALT;
    #1 check_eq("t5b_halt_en", cpu_en, 0);
    cyc();
    exp_cnt += 2;
    check_eq("t5b_state", state, 0);
    check_eq("t5b_done", done, 0);
    cyc();
    check_eq("t5b_done_later", done, 0);
    check_eq("t5b_cnt", cycle_cnt, exp_cnt);

    // 6: HALT beats resume in the same cycle; no stale skip afterwards
    bp_addr = {32'h0, 32'h0000_0300}; bp_en = 2'b01; pc = 32'h300; mode = M_RUN;
    cyc();
    check_eq("t6_run_en", cpu_en, 0);
    cyc();
    check_eq("t6_state_brk", state, 3);
    resume = 1'b1; mode = M_HALT;
    #1 check_eq("t6_same_en", cpu_en, 0);
    cyc();
    resume = 1'b0;
    check_eq("t6_state_idle", state, 0);
    check_eq("t6_en", cpu_en, 0);
    mode = M_RUN;
    cyc();
    check_eq("t6_rerun_en", cpu_en, 0);
    cyc();
    check_eq("t6_rebreak", state, 3);
    check_eq("t6_cnt", cycle_cnt, exp_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
